// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences one or two aligned word transactions per access,
// merges/extends load data and lane-shifts store data with byte enables.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        dm_req,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_web,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;

    logic [1:0]  off;
    logic [31:0] base_addr;
    logic [3:0]  size_mask;
    logic [7:0]  web_span;
    logic [63:0] wdata_span;
    logic [31:0] rd_word;
    logic [31:0] ext_data;

    function automatic logic is_legal(input logic [2:0] f3, input logic we);
        case (f3)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b100, 3'b101:         is_legal = !we;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    // Only called for legal funct3, so the low two bits identify the size.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] a_off);
        is_split = ((f3[1:0] == 2'b01) && (a_off == 2'b11)) ||
                   ((f3[1:0] == 2'b10) && (a_off != 2'b00));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    we_d    = mem_we;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    // Clearing hi keeps the merge correct for non-split accesses.
                    lo_d    = 32'h0;
                    hi_d    = 32'h0;
                    state_d = is_legal(funct3, mem_we) ? ACC0 : DONE;
                end
            end
            ACC0: begin
                if (dm_ack) begin
                    lo_d    = dm_rdata;
                    state_d = is_split(f3_q, addr_q[1:0]) ? ACC1 : DONE;
                end
            end
            ACC1: begin
                if (dm_ack) begin
                    hi_d    = dm_rdata;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign off        = addr_q[1:0];
    assign base_addr  = {addr_q[31:2], 2'b00};
    assign web_span   = {4'b0000, size_mask} << off;
    assign wdata_span = {32'h0, wdata_q} << {off, 3'b000};
    assign rd_word    = 32'({hi_q, lo_q} >> {off, 3'b000});

    always_comb begin
        size_mask = 4'b0000;
        case (f3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            2'b10:   size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    end

    always_comb begin
        ext_data = 32'h0;
        case (f3_q)
            3'b000:  ext_data = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b100:  ext_data = {24'h0, rd_word[7:0]};
            3'b001:  ext_data = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b101:  ext_data = {16'h0, rd_word[15:0]};
            3'b010:  ext_data = rd_word;
            default: ext_data = 32'h0;
        endcase
    end

    // Memory-side outputs depend only on registered state, never on dm_ack.
    always_comb begin
        dm_req    = 1'b0;
        dm_addr   = 32'h0;
        dm_web    = 4'b0000;
        dm_wdata  = 32'h0;
        lsu_done  = 1'b0;
        lsu_rdata = 32'h0;
        case (state_q)
            ACC0: begin
                dm_req  = 1'b1;
                dm_addr = base_addr;
                if (we_q) begin
                    dm_web   = web_span[3:0];
                    dm_wdata = wdata_span[31:0];
                end
            end
            ACC1: begin
                dm_req  = 1'b1;
                dm_addr = base_addr + 32'd4;
                if (we_q) begin
                    dm_web   = web_span[7:4];
                    dm_wdata = wdata_span[63:32];
                end
            end
            DONE: begin
                lsu_done = 1'b1;
                if (!we_q && is_legal(f3_q, we_q)) begin
                    lsu_rdata = ext_data;
                end
            end
            default: ;
        endcase
    end

    assign lsu_stall = mem_req && (state_q != DONE);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: a byte-addressed memory responder with configurable
// wait states, and a byte-level reference model for load results and store lanes.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        dm_req;
    logic [31:0] dm_addr;
    logic [3:0]  dm_web;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  memBytes [logic [31:0]];
    int          waitCfg = 0;
    logic        forceAck = 1'b0;
    logic [31:0] txAddr[$];
    logic [3:0]  txWeb[$];
    logic [31:0] txWdata[$];
    int          lastLatency;
    logic [31:0] lastRdata;

    lsu_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .lsu_stall (lsu_stall),
        .lsu_done  (lsu_done),
        .lsu_rdata (lsu_rdata),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_web    (dm_web),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Untouched memory returns an address-derived pattern so every byte is distinctive.
    function automatic logic [7:0] readByte(input logic [31:0] a);
        if (memBytes.exists(a)) return memBytes[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic void writeWord(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) memBytes[32'(a + i)] = w[8*i +: 8];
    endfunction

    // Memory responder: acks after waitCfg wait cycles and checks outputs hold steady meanwhile.
    initial begin : responder
        logic [31:0] snapAddr;
        logic [35:0] snapData;
        logic [31:0] word;
        int          waitCnt;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        waitCnt  = 0;
        forever begin
            @(negedge clk);
            dm_ack   = 1'b0;
            dm_rdata = $urandom;
            if (rst || !dm_req) begin
                waitCnt = 0;
                dm_ack  = forceAck;
            end else begin
                if (waitCnt == 0) begin
                    snapAddr = dm_addr;
                    snapData = {dm_web, dm_wdata};
                end else begin
                    checkOutput("dm_addr_stable", dm_addr, snapAddr);
                    checkOutput("dm_write_stable", {dm_web, dm_wdata}, snapData);
                end
                if (waitCnt >= waitCfg) begin
                    word = 32'h0;
                    for (int i = 0; i < 4; i++) word[8*i +: 8] = readByte(32'(dm_addr + i));
                    for (int i = 0; i < 4; i++)
                        if (dm_web[i]) memBytes[32'(dm_addr + i)] = dm_wdata[8*i +: 8];
                    dm_rdata = word;
                    dm_ack   = 1'b1;
                    txAddr.push_back(dm_addr);
                    txWeb.push_back(dm_web);
                    txWdata.push_back(dm_wdata);
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int waits);
        int          size;
        int          nTx;
        int          expLat;
        int          off;
        int          k;
        logic        legal;
        logic        seen;
        logic [31:0] expRd;
        logic [31:0] base;
        logic [3:0]  expWeb[2];
        logic [31:0] expWd[2];

        @(negedge clk);
        checkOutput("done_one_cycle", lsu_done, 1'b0);
        txAddr.delete();
        txWeb.delete();
        txWdata.delete();
        waitCfg = waits;
        mem_req = 1'b1;
        mem_we  = we;
        funct3  = f3;
        addr    = a;
        wdata   = wd;

        case (f3[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            default: size = 4;
        endcase
        legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        off    = int'(a[1:0]);
        nTx    = !legal ? 0 : ((off + size > 4) ? 2 : 1);
        expLat = 1 + nTx * (1 + waits);
        base   = {a[31:2], 2'b00};

        expRd = 32'h0;
        if (legal && !we) begin
            for (int i = 0; i < size; i++) expRd[8*i +: 8] = readByte(32'(a + i));
            if (!f3[2] && size < 4 && expRd[8*size-1])
                for (int i = size; i < 4; i++) expRd[8*i +: 8] = 8'hFF;
        end

        expWeb = '{4'h0, 4'h0};
        expWd  = '{32'h0, 32'h0};
        if (legal && we) begin
            for (int i = 0; i < 4; i++) begin
                int p;
                p = off + i;
                expWd[p/4][8*(p%4) +: 8] = wd[8*i +: 8];
                if (i < size) expWeb[p/4][p%4] = 1'b1;
            end
        end

        k    = 0;
        seen = 1'b0;
        while (k < 60 && !seen) begin
            @(negedge clk);
            k++;
            if (lsu_done) seen = 1'b1;
            else checkOutput("stall_while_busy", lsu_stall, 1'b1);
        end
        checkOutput("done_seen", seen, 1'b1);
        lastLatency = k;
        lastRdata   = lsu_rdata;
        if (seen) begin
            checkOutput("latency", k, expLat);
            checkOutput("lsu_rdata", lsu_rdata, expRd);
            checkOutput("stall_on_done", lsu_stall, 1'b0);
        end
        checkOutput("tx_count", txAddr.size(), nTx);
        for (int t = 0; t < nTx && t < txAddr.size(); t++) begin
            checkOutput("tx_addr", txAddr[t], 32'(base + 32'(4 * t)));
            checkOutput("tx_web", txWeb[t], expWeb[t]);
            checkOutput("tx_wdata", txWdata[t], expWd[t]);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_req = 1'b0;
        end
    endtask

    // Reset while the second transaction of a split load is waiting, then offer a stray ack.
    task automatic resetMidAccess();
        logic reached;
        int   k;
        @(negedge clk);
        txAddr.delete();
        txWeb.delete();
        txWdata.delete();
        waitCfg = 2;
        mem_req = 1'b1;
        mem_we  = 1'b0;
        funct3  = 3'b010;
        addr    = 32'h0000_0102;
        wdata   = 32'h0;
        reached = 1'b0;
        k       = 0;
        while (k < 20 && !reached) begin
            @(negedge clk);
            k++;
            if (dm_req && dm_addr == 32'h0000_0104) reached = 1'b1;
        end
        checkOutput("reached_acc1", reached, 1'b1);
        waitCfg = 100;
        rst     = 1'b1;
        mem_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_dm_req", dm_req, 1'b0);
        checkOutput("rst_done", lsu_done, 1'b0);
        rst      = 1'b0;
        forceAck = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("late_ack_req", dm_req, 1'b0);
            checkOutput("late_ack_done", lsu_done, 1'b0);
        end
        forceAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("after_rst_done", lsu_done, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] baseSel;
        rst     = 1'b1;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        funct3  = 3'b000;
        addr    = 32'h0;
        wdata   = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dm_req", dm_req, 1'b0);
        checkOutput("reset_dm_addr", dm_addr, 32'h0);
        checkOutput("reset_dm_web", dm_web, 4'h0);
        checkOutput("reset_dm_wdata", dm_wdata, 32'h0);
        checkOutput("reset_done", lsu_done, 1'b0);
        checkOutput("reset_rdata", lsu_rdata, 32'h0);
        checkOutput("reset_stall", lsu_stall, 1'b0);
        rst = 1'b0;

        writeWord(32'h0000_0100, 32'h8899_AABB);
        applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0);
        checkOutput("lw_aligned_value", lastRdata, 32'h8899_AABB);
        checkOutput("lw_aligned_latency", lastLatency, 2);

        writeWord(32'h0000_0200, 32'h8011_2233);
        applyStimulus(1'b0, 3'b000, 32'h0000_0203, 32'h0, 0);
        checkOutput("lb_off3_value", lastRdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h0000_0203, 32'h0, 0);
        checkOutput("lbu_off3_value", lastRdata, 32'h0000_0080);

        writeWord(32'h0000_0100, 32'h4433_2211);
        writeWord(32'h0000_0104, 32'h8877_6655);
        applyStimulus(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0);
        checkOutput("lw_split_value", lastRdata, 32'h6655_4433);
        checkOutput("lw_split_latency", lastLatency, 3);

        applyStimulus(1'b1, 3'b001, 32'h0000_0007, 32'h0000_BEEF, 0);
        checkOutput("sh_split_count", txWeb.size(), 2);
        if (txWeb.size() == 2) begin
            checkOutput("sh_split_web0", txWeb[0], 4'b1000);
            checkOutput("sh_split_wd0", txWdata[0], 32'hEF00_0000);
            checkOutput("sh_split_web1", txWeb[1], 4'b0001);
            checkOutput("sh_split_wd1", txWdata[1], 32'h0000_00BE);
        end

        applyStimulus(1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0, 3);
        checkOutput("wrap_latency", lastLatency, 9);

        resetMidAccess();

        applyStimulus(1'b0, 3'b011, 32'h0000_0040, 32'h0, 0);
        checkOutput("illegal_latency", lastLatency, 1);
        checkOutput("illegal_rdata", lastRdata, 32'h0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            case (r[9:8])
                2'd0:    baseSel = 32'h0000_0100;
                2'd1:    baseSel = 32'hFFFF_FFE0;
                2'd2:    baseSel = 32'h0000_0000;
                default: baseSel = 32'h0000_0200;
            endcase
            applyStimulus(r[0],
                          (r[7:5] == 3'b000) ? r[3:1] : {r[3], 1'b0, r[4] & ~r[1]} | {1'b0, r[2] & ~r[4], 1'b0},
                          32'(baseSel + 32'($urandom_range(0, 47))),
                          $urandom,
                          (r[12:11] == 2'b00) ? int'($urandom_range(1, 3)) : 0);
            if (r[15:14] == 2'b00) idleCycles(int'($urandom_range(1, 3)));
        end

        idleCycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller between the MEM stage and the data memory port. It accepts one access per request, and splits any misaligned halfword/word access into two aligned word transactions. It sequences those transactions over a req/ack handshake, then merges and extends load data or generates byte-enabled store data. It stalls the pipeline until the access completes and replaces the MEM stage's direct data-memory connection and load extraction.

## Interface
- No parameters; address and data widths are fixed at 32.
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `mem_req`  in  1  — MEM stage holds a load/store; held stable with `mem_we`/`funct3`/`addr`/`wdata` until `lsu_done`.
- `mem_we`  in  1  — 1 = store, 0 = load.
- `funct3`  in  3  — 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `addr`  in  32  — byte address.
- `wdata`  in  32  — store data, right-aligned.
- `lsu_stall`  out  1  — freeze pipeline.
- `lsu_done`  out  1  — one-cycle completion pulse.
- `lsu_rdata`  out  32  — extended load result, valid while `lsu_done`=1.
- `dm_req`  out  1  — memory request.
- `dm_addr`  out  32  — word address, bits [1:0] always 0.
- `dm_web`  out  4  — active-high byte write enables; 0000 on reads.
- `dm_wdata`  out  32  — lane-shifted store data.
- `dm_ack`  in  1  — transaction accepted/complete; `dm_rdata` valid in the same cycle.
- `dm_rdata`  in  32  — read word.

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- **IDLE**
  - On `mem_req`, latch `mem_we`, `funct3`, `addr`, `wdata`; let off = `addr[1:0]`.
  - split = (H/HU and off=11) or (W and off≠00).
  - Legal funct3 → ACC0. Illegal (011, 110, 111; or 100/101 with `mem_we`) → DONE with no memory access.
- **ACC0**
  - `dm_req`=1, `dm_addr`={addr[31:2],00}.
  - Hold all dm outputs stable until `dm_ack`.
  - On ack, capture `dm_rdata` into lo; go to ACC1 if split, else DONE.
- **ACC1**
  - `dm_req`=1, `dm_addr`={addr[31:2],00}+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
  - On ack, capture hi → DONE.
- **DONE**: `lsu_done`=1 for exactly one cycle, then → IDLE.
- **Load merge**
  - v = ({hi,lo} >> 8·off)[31:0].
  - B/BU sign-/zero-extend v[7:0]; H/HU sign-/zero-extend v[15:0]; W passes v.
  - The unused hi register is 0 when not split.
- **Store generation**
  - m = 0001 (B), 0011 (H), 1111 (W).
  - M = {4'b0,m} << off (8 bits); D = {32'b0,wdata} << 8·off (64 bits).
  - ACC0 drives `dm_web`=M[3:0], `dm_wdata`=D[31:0]; ACC1 drives M[7:4], D[63:32].
  - Reads drive `dm_web`=0000, `dm_wdata`=0.
- `lsu_rdata` = 0 for stores and illegal accesses.
- `dm_ack` is ignored in IDLE/DONE.
- `lsu_stall` = `mem_req` and state≠DONE.

## Timing
- Reset (sync): state=IDLE.
  - `dm_req`=0, `dm_addr`=0, `dm_web`=0, `dm_wdata`=0.
  - `lsu_done`=0, `lsu_rdata`=0, `lsu_stall`=0 (while `mem_req`=0).
  - lo/hi=0.
- Reset mid-access abandons the transaction; `dm_req` is low in the cycle after the reset edge, and a late `dm_ack` is ignored.
- `dm_req`, `dm_addr`, `dm_web`, `dm_wdata`, `lsu_done` decode from registered state/latches only, with no combinational path from `dm_ack`.
- Latency from the `mem_req` cycle (N):
  - With zero-wait ack: aligned → `lsu_done` at N+2; split → N+3; illegal → N+1.
  - Each memory wait cycle adds one.
- Pipeline advances on the `lsu_done` cycle. A new `mem_req` is sampled in IDLE at the earliest cycle after DONE, so back-to-back accesses have one IDLE cycle between them.

## Test plan
- **Aligned LW**: addr 0x100, `dm_rdata`=0x8899AABB, ack in ACC0 with 0 waits → one `dm_req` at `dm_addr` 0x100, `lsu_done` at N+2, `lsu_rdata`=0x8899AABB.
- **LB/LBU off=11**: `dm_rdata`=0x80112233 → LB gives 0xFFFFFF80, LBU gives 0x00000080.
- **Split LW**: addr 0x102, words 0x44332211 / 0x88776655 → accesses at 0x100 then 0x104, `lsu_rdata`=0x66554433, `lsu_done` at N+3.
- **Split SH**: addr 0x7, wdata 0x0000BEEF → ACC0 `dm_web`=1000 / `dm_wdata`=0xEF000000 at 0x4; ACC1 `dm_web`=0001 / `dm_wdata`=0x000000BE at 0x8.
- **Wait states and wrap**: 3-cycle ack delay on split LW at 0xFFFFFFFD → dm outputs stable across waits, second `dm_addr`=0x00000000, `lsu_stall` high until the `lsu_done` cycle.
- **Reset in ACC1 plus illegal op**:
  - Reset asserted in ACC1 → `dm_req`=0 the next cycle, no `lsu_done`.
  - funct3=011 load → no `dm_req`, `lsu_done` at N+1, `lsu_rdata`=0.
